// File: rtl/isp_color_pipeline.sv
// Bayer-raw ISP back end: per-site white balance, piecewise gamma lift and 8-bit RGB packing.
// Tracks line/frame position from data_en bursts; fixed 4-cycle latency, one pixel per clock.
module isp_color_pipeline #(
  parameter int unsigned DW  = 12,
  parameter int unsigned FCW = 16
) (
  input  logic           isp_clk,
  input  logic           rst,
  input  logic [15:0]    isp_data_in,
  input  logic [11:0]    h_active_in,
  input  logic [11:0]    v_active_in,
  input  logic [3:0]     bayerStart,
  input  logic           data_en,
  input  logic [2:0]     mode_sel,
  input  logic [7:0]     r_gain,
  input  logic [7:0]     g_gain,
  input  logic [7:0]     b_gain,
  input  logic [2:0]     gamma_coe,
  output logic [23:0]    rgb_out,
  output logic           rgb_valid,
  output logic [FCW-1:0] frames_cnt
);

  localparam logic [1:0]    ChR    = 2'd0;
  localparam logic [1:0]    ChG    = 2'd1;
  localparam logic [1:0]    ChB    = 2'd2;
  localparam logic [DW-1:0] PixMax = '1;

  // Position state
  logic [11:0]    col_q, col_d, row_q, row_d;
  logic [FCW-1:0] frames_q, frames_d;
  logic           de_q;

  // Input-stage decode
  logic           flip_r, flip_c, site_r, site_c;
  logic [1:0]     chan_in;
  logic [7:0]     gain_in;
  logic           wb_in, gm_in, gray_in, pix_ok;

  // Pipeline stages: s0 capture, s1 white balance, s2 gamma term, s3 gamma sum
  logic           s0_vld_q, s1_vld_q, s2_vld_q, s3_vld_q;
  logic [DW-1:0]  s0_raw_q, s1_pix_q, s2_pix_q, s3_pix_q;
  logic [1:0]     s0_chan_q, s1_chan_q, s2_chan_q, s3_chan_q;
  logic           s0_gray_q, s1_gray_q, s2_gray_q, s3_gray_q;
  logic           s0_gm_q, s1_gm_q, s2_gm_q;
  logic [2:0]     s0_k_q, s1_k_q, s2_k_q;
  logic [7:0]     s0_gain_q;
  logic           s0_wb_q;
  logic [DW-1:0]  s2_t_q;

  logic [DW+7:0]  wb_prod;
  logic [DW+1:0]  wb_scaled;
  logic [DW-1:0]  s1_pix_d;
  logic [2*DW-1:0] gm_prod;
  logic [DW+2:0]  gm_tk;
  logic [DW+1:0]  gm_sum;
  logic [DW-1:0]  s3_pix_d;
  logic [7:0]     pix8;
  logic [23:0]    rgb_q, rgb_d;
  logic           rgb_valid_q;

  // Decode CFA site, per-pixel gain, mode flags and active-window drop for the incoming pixel
  always_comb begin
    flip_r = 1'b0;
    flip_c = 1'b0;
    case (bayerStart)
      4'b0010: flip_c = 1'b1;
      4'b0100: flip_r = 1'b1;
      4'b1000: begin
        flip_r = 1'b1;
        flip_c = 1'b1;
      end
      default: ;
    endcase
    // Phases are the RGGB pattern shifted by one row and/or column
    site_r = row_q[0] ^ flip_r;
    site_c = col_q[0] ^ flip_c;
    if (!site_r && !site_c) begin
      chan_in = ChR;
      gain_in = r_gain;
    end else if (site_r && site_c) begin
      chan_in = ChB;
      gain_in = b_gain;
    end else begin
      chan_in = ChG;
      gain_in = g_gain;
    end
    wb_in   = 1'b0;
    gm_in   = 1'b0;
    gray_in = 1'b0;
    case (mode_sel)
      3'b000:  gray_in = 1'b1;
      3'b001:  wb_in   = 1'b1;
      3'b010:  gm_in   = 1'b1;
      default: begin
        wb_in = 1'b1;
        gm_in = 1'b1;
      end
    endcase
    pix_ok = data_en && (col_q < h_active_in) && (row_q < v_active_in);
  end

  // Next column/row/frame from data_en bursts; a falling edge closes a line
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    frames_d = frames_q;
    if (data_en) begin
      // Saturate so an over-long line never wraps back into the active window
      if (col_q != 12'hFFF) col_d = col_q + 12'd1;
    end else if (de_q) begin
      col_d = 12'd0;
      if ({1'b0, row_q} + 13'd1 >= {1'b0, v_active_in}) begin
        row_d    = 12'd0;
        frames_d = frames_q + 1'b1;
      end else begin
        row_d = row_q + 12'd1;
      end
    end
  end

  // Position registers
  always_ff @(posedge isp_clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      frames_q <= '0;
      de_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      frames_q <= frames_d;
      de_q     <= data_en;
    end
  end

  // White balance: Q2.6 gain, saturate to full scale
  always_comb begin
    wb_prod   = (DW + 8)'(s0_raw_q) * (DW + 8)'(s0_gain_q);
    wb_scaled = wb_prod[DW+7:6];
    if (!s0_wb_q) begin
      s1_pix_d = s0_raw_q;
    end else if (|wb_scaled[DW+1:DW]) begin
      s1_pix_d = PixMax;
    end else begin
      s1_pix_d = wb_scaled[DW-1:0];
    end
  end

  // Gamma: parabolic lift t = x(max-x)/2^DW, then y = min(max, x + t*k/2)
  always_comb begin
    gm_prod = (2 * DW)'(s1_pix_q) * (2 * DW)'(PixMax - s1_pix_q);
    gm_tk   = (DW + 3)'(s2_t_q) * (DW + 3)'(s2_k_q);
    gm_sum  = (DW + 2)'(s2_pix_q) + (DW + 2)'(gm_tk >> 1);
    if (!s2_gm_q) begin
      s3_pix_d = s2_pix_q;
    end else if (gm_sum > (DW + 2)'(PixMax)) begin
      s3_pix_d = PixMax;
    end else begin
      s3_pix_d = gm_sum[DW-1:0];
    end
  end

  // Pack: gray replicates, mosaic places the sample in its own channel slot; hold otherwise
  always_comb begin
    pix8  = s3_pix_q[DW-1:DW-8];
    rgb_d = rgb_q;
    if (s3_vld_q) begin
      if (s3_gray_q) begin
        rgb_d = {pix8, pix8, pix8};
      end else begin
        case (s3_chan_q)
          ChR:     rgb_d = {pix8, 8'h00, 8'h00};
          ChB:     rgb_d = {8'h00, 8'h00, pix8};
          default: rgb_d = {8'h00, pix8, 8'h00};
        endcase
      end
    end
  end

  // Valid chain and output registers; reset discards pixels in flight
  always_ff @(posedge isp_clk) begin
    if (rst) begin
      s0_vld_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      s0_vld_q    <= pix_ok;
      s1_vld_q    <= s0_vld_q;
      s2_vld_q    <= s1_vld_q;
      s3_vld_q    <= s2_vld_q;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s3_vld_q;
    end
  end

  // Pixel data and per-pixel config travelling alongside the valid chain
  always_ff @(posedge isp_clk) begin
    s0_raw_q  <= isp_data_in[15 -: DW];
    s0_chan_q <= chan_in;
    s0_gain_q <= gain_in;
    s0_wb_q   <= wb_in;
    s0_gm_q   <= gm_in;
    s0_gray_q <= gray_in;
    s0_k_q    <= gamma_coe;

    s1_pix_q  <= s1_pix_d;
    s1_chan_q <= s0_chan_q;
    s1_gm_q   <= s0_gm_q;
    s1_gray_q <= s0_gray_q;
    s1_k_q    <= s0_k_q;

    s2_pix_q  <= s1_pix_q;
    s2_t_q    <= gm_prod[2*DW-1:DW];
    s2_chan_q <= s1_chan_q;
    s2_gm_q   <= s1_gm_q;
    s2_gray_q <= s1_gray_q;
    s2_k_q    <= s1_k_q;

    s3_pix_q  <= s3_pix_d;
    s3_chan_q <= s2_chan_q;
    s3_gray_q <= s2_gray_q;
  end

  assign rgb_out    = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign frames_cnt = frames_q;

endmodule

// File: tb/tb_isp_color_pipeline.sv
// Randomized bench for isp_color_pipeline against a behavioural pixel/position model.
module tb_isp_color_pipeline;

  logic        isp_clk = 1'b0;
  logic        rst;
  logic [15:0] isp_data_in;
  logic [11:0] h_active_in, v_active_in;
  logic [3:0]  bayerStart;
  logic        data_en;
  logic [2:0]  mode_sel;
  logic [7:0]  r_gain, g_gain, b_gain;
  logic [2:0]  gamma_coe;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic [15:0] frames_cnt;

  always #5 isp_clk = ~isp_clk;

  isp_color_pipeline #(.DW(12), .FCW(16)) dut (
    .isp_clk     (isp_clk),
    .rst         (rst),
    .isp_data_in (isp_data_in),
    .h_active_in (h_active_in),
    .v_active_in (v_active_in),
    .bayerStart  (bayerStart),
    .data_en     (data_en),
    .mode_sel    (mode_sel),
    .r_gain      (r_gain),
    .g_gain      (g_gain),
    .b_gain      (b_gain),
    .gamma_coe   (gamma_coe),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .frames_cnt  (frames_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [23:0] rgb;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_row, m_col, m_valid_cnt;
  bit          m_prev_de;
  logic [15:0] m_frames;
  logic [23:0] m_hold;
  exp_t        m_q[$];
  // Channel per CFA phase (RGGB, GRBG, GBRG, BGGR) and site index row0*2+col0; 0=R 1=G 2=B
  int          cfa[4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int raw, input int chan, input int mode,
                                          input int gain, input int k);
    int         v;
    logic [7:0] b;
    v = raw;
    if (mode != 0 && mode != 2) begin
      v = raw * gain / 64;
      if (v > 4095) v = 4095;
    end
    if (mode != 0 && mode != 1) begin
      v = v + ((v * (4095 - v)) / 4096) * k / 2;
      if (v > 4095) v = 4095;
    end
    b = 8'(v / 16);
    if (mode == 0) return {b, b, b};
    if (chan == 0) return {b, 8'h00, 8'h00};
    if (chan == 2) return {8'h00, 8'h00, b};
    return {8'h00, b, 8'h00};
  endfunction

  function automatic int phase_of(input logic [3:0] bs);
    case (bs)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  // One clock: predict from current inputs, advance, compare against the prediction 4 edges old
  task automatic step();
    exp_t e;
    int   chan, gain;
    if (rst) begin
      @(posedge isp_clk);
      #1;
      m_row = 0; m_col = 0; m_prev_de = 1'b0; m_frames = '0; m_hold = '0;
      m_q.delete();
      repeat (4) m_q.push_back('0);
      check_val("rst_rgb", 32'(rgb_out), 32'h0);
      check_val("rst_valid", 32'(rgb_valid), 32'h0);
      check_val("rst_frames", 32'(frames_cnt), 32'h0);
    end else begin
      e = '0;
      if (data_en) begin
        if (m_col < int'(h_active_in) && m_row < int'(v_active_in)) begin
          chan = cfa[phase_of(bayerStart)][(m_row % 2) * 2 + (m_col % 2)];
          gain = (chan == 0) ? int'(r_gain) : (chan == 2) ? int'(b_gain) : int'(g_gain);
          e.v   = 1'b1;
          e.rgb = ref_rgb(int'(isp_data_in[15:4]), chan, int'(mode_sel), gain, int'(gamma_coe));
        end
        m_col++;
      end else if (m_prev_de) begin
        m_col = 0;
        m_row++;
        if (m_row >= int'(v_active_in)) begin
          m_row = 0;
          m_frames++;
        end
      end
      m_prev_de = data_en;
      m_q.push_back(e);
      @(posedge isp_clk);
      #1;
      e = m_q.pop_front();
      if (e.v) m_hold = e.rgb;
      if (rgb_valid) m_valid_cnt++;
      check_val("valid", 32'(rgb_valid), 32'(e.v));
      check_val("rgb", 32'(rgb_out), 32'(m_hold));
      check_val("frames", 32'(frames_cnt), 32'(m_frames));
    end
  endtask

  task automatic rand_pixel();
    isp_data_in = 16'($urandom);
    bayerStart  = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
    mode_sel    = 3'($urandom);
    r_gain      = 8'($urandom);
    g_gain      = 8'($urandom);
    b_gain      = 8'($urandom);
    gamma_coe   = 3'($urandom);
  endtask

  // Single pixel at row 0 / col 0 straight after reset, compared to a literal result
  task automatic directed(input string tag, input logic [11:0] raw, input logic [3:0] bs,
                          input logic [2:0] mode, input logic [7:0] rg, input logic [7:0] gg,
                          input logic [7:0] bg, input logic [2:0] k, input logic [23:0] exp);
    rst = 1'b1; data_en = 1'b0;
    step();
    rst = 1'b0;
    h_active_in = 12'd64; v_active_in = 12'd64;
    isp_data_in = {raw, 4'($urandom)};
    bayerStart = bs; mode_sel = mode; r_gain = rg; g_gain = gg; b_gain = bg; gamma_coe = k;
    data_en = 1'b1;
    step();
    data_en = 1'b0;
    rand_pixel();
    repeat (4) step();
    check_val(tag, 32'(rgb_out), 32'(exp));
    check_val({tag, "_valid"}, 32'(rgb_valid), 32'h1);
  endtask

  initial begin
    rst = 1'b1; data_en = 1'b0; isp_data_in = '0; h_active_in = 12'd16; v_active_in = 12'd32;
    bayerStart = 4'b0001; mode_sel = 3'b100; r_gain = 8'h40; g_gain = 8'h40; b_gain = 8'h40;
    gamma_coe = 3'd0; m_valid_cnt = 0;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    directed("rggb_wb_gamma", 12'h400, 4'b0001, 3'b100, 8'hE0, 8'h40, 8'h40, 3'd1, 24'hED0000);
    directed("rggb_wb_only", 12'h400, 4'b0001, 3'b001, 8'hE0, 8'h40, 8'h40, 3'd1, 24'hE00000);
    directed("wb_saturate", 12'hFFF, 4'b0001, 3'b100, 8'hE0, 8'h40, 8'h40, 3'd1, 24'hFF0000);
    directed("gray_bypass", 12'hABC, 4'b0001, 3'b000, 8'hE0, 8'h11, 8'h22, 3'd5, 24'hABABAB);
    directed("bggr_blue", 12'h800, 4'b1000, 3'b001, 8'h80, 8'h80, 8'h40, 3'd3, 24'h000080);

    // Active-window drop and frame counting: 22-pixel bursts into a 16x32 window
    rst = 1'b1;
    step();
    rst = 1'b0;
    h_active_in = 12'h010; v_active_in = 12'h020;
    m_valid_cnt = 0;
    for (int b = 0; b < 200; b++) begin
      for (int p = 0; p < 22; p++) begin
        rand_pixel();
        data_en = 1'b1;
        step();
      end
      data_en = 1'b0;
      repeat (2) step();
    end
    repeat (4) step();
    check_val("frames_200_bursts", 32'(frames_cnt), 32'd6);
    check_val("valids_200_bursts", 32'(m_valid_cnt), 32'd3200);

    // Mid-burst reset: in-flight pixels vanish, next burst restarts at row 0 / col 0
    h_active_in = 12'd64; v_active_in = 12'd8;
    for (int b = 0; b < 3; b++) begin
      for (int p = 0; p < 10; p++) begin
        rand_pixel();
        data_en = 1'b1;
        step();
      end
      data_en = 1'b0;
      step();
    end
    for (int p = 0; p < 5; p++) begin
      rand_pixel();
      data_en = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; data_en = 1'b0;
    repeat (2) step();
    isp_data_in = 16'h1235; bayerStart = 4'b0001; mode_sel = 3'b001;
    r_gain = 8'h40; g_gain = 8'h80; b_gain = 8'h80;
    data_en = 1'b1;
    step();
    data_en = 1'b0;
    repeat (4) step();
    check_val("post_rst_origin", 32'(rgb_out), 32'h120000);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
